// File: rtl/reg_cmd_seq.sv
// reg_cmd_seq
// Command sequencer sitting in front of a 4-bit universal register.
// Each accepted command is expanded into a train of single-cycle control
// strobes (cl/ld/inc/dec/sr/sl) with matching serial fill bits, so that
// "increment by N", "shift by N" and "rotate by N" become N strobe cycles.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake; ready only while idle
//   cmd_op              0 NOP, 1 CLR, 2 LOAD, 3 INC, 4 DEC, 5 SHR, 6 SHL, 7 ROR
//   cmd_arg             LOAD data, or repeat count for INC/DEC/SHR/SHL/ROR
//   cmd_fill            serial fill bit for SHR/SHL
//   abort               cancels the remaining strobes of the running command
//   reg_q               register output fed back (ROR fill source)
//   cl..sl, ir, il      register control strobes and serial fill bits
//   ld_data             parallel-load data, valid while ld is high
//   busy, done          command in progress / one-cycle completion pulse
module reg_cmd_seq #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_arg,
  input  logic              cmd_fill,
  input  logic              abort,
  input  logic [DATA_W-1:0] reg_q,
  output logic              cl,
  output logic              ld,
  output logic              inc,
  output logic              dec,
  output logic              sr,
  output logic              sl,
  output logic              ir,
  output logic              il,
  output logic [DATA_W-1:0] ld_data,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_CLR  = 3'd1;
  localparam logic [2:0] OP_LOAD = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_DEC  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_ROR  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [2:0]        op_q, op_next;
  logic [DATA_W-1:0] arg_q, arg_next;
  logic              fill_q, fill_next;
  logic [DATA_W-1:0] count_q, count_next;
  logic [DATA_W-1:0] accept_count;

  // Only bit 0 of the feedback is used (ROR fill); the rest is dropped here.
  logic unused_reg_bits;
  assign unused_reg_bits = ^reg_q[DATA_W-1:1];

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // State and latched command. Reset clears everything at once, which also
  // kills any strobe train in flight because the strobes decode this state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= 3'd0;
      arg_q   <= '0;
      fill_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state   <= state_next;
      op_q    <= op_next;
      arg_q   <= arg_next;
      fill_q  <= fill_next;
      count_q <= count_next;
    end
  end

  // Number of strobe cycles a newly accepted command expands into.
  always_comb begin
    accept_count = cmd_arg;
    case (cmd_op)
      OP_NOP:          accept_count = '0;
      OP_CLR, OP_LOAD: accept_count = DATA_W'(1);
      default:         accept_count = cmd_arg;
    endcase
  end

  // Next-state logic and strobe decode. Strobes only ever come from RUN and
  // the latched opcode; ROR takes its fill straight from the register so each
  // step sees the value left by the previous strobe.
  always_comb begin
    state_next = state;
    op_next    = op_q;
    arg_next   = arg_q;
    fill_next  = fill_q;
    count_next = count_q;
    cl         = 1'b0;
    ld         = 1'b0;
    inc        = 1'b0;
    dec        = 1'b0;
    sr         = 1'b0;
    sl         = 1'b0;
    ir         = 1'b0;
    il         = 1'b0;
    ld_data    = '0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          op_next    = cmd_op;
          arg_next   = cmd_arg;
          fill_next  = cmd_fill;
          count_next = accept_count;
          if (cmd_op == OP_NOP || accept_count == '0) begin
            state_next = FIN;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        case (op_q)
          OP_CLR:  cl = 1'b1;
          OP_LOAD: begin
            ld      = 1'b1;
            ld_data = arg_q;
          end
          OP_INC:  inc = 1'b1;
          OP_DEC:  dec = 1'b1;
          OP_SHR: begin
            sr = 1'b1;
            ir = fill_q;
          end
          OP_ROR: begin
            sr = 1'b1;
            ir = reg_q[0];
          end
          OP_SHL: begin
            sl = 1'b1;
            il = fill_q;
          end
          default: ;
        endcase
        count_next = count_q - DATA_W'(1);
        if (count_q == DATA_W'(1) || abort) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_cmd_seq.sv
// tb_reg_cmd_seq
// Self-checking bench for reg_cmd_seq. A behavioural 4-bit universal register
// closes the reg_q feedback loop. Expected strobe trains and register values
// are derived from the command semantics (repeat counts, abort cut-off,
// arithmetic rotate/shift) rather than from the sequencer's state machine.
module tb_reg_cmd_seq;

  localparam int DATA_W = 4;
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_CLR  = 3'd1;
  localparam logic [2:0] OP_LOAD = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_DEC  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_ROR  = 3'd7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_arg;
  logic              cmd_fill;
  logic              abort;
  logic [DATA_W-1:0] reg_q;
  logic              cl, ld, inc, dec, sr, sl, ir, il;
  logic [DATA_W-1:0] ld_data;
  logic              busy, done;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Per-cycle record of one command, index 1 = first cycle after accept.
  logic [5:0] tr_strb [48];
  logic       tr_ir   [48];
  logic       tr_il   [48];
  logic [3:0] tr_ldd  [48];
  logic       tr_done [48];
  int         tr_len;

  logic [3:0] model_q;

  always #5 clk = ~clk;

  reg_cmd_seq #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_fill(cmd_fill), .abort(abort),
    .reg_q(reg_q), .cl(cl), .ld(ld), .inc(inc), .dec(dec), .sr(sr), .sl(sl),
    .ir(ir), .il(il), .ld_data(ld_data), .busy(busy), .done(done)
  );

  // Universal register driven by the sequencer, reset together with it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   reg_q <= 4'd0;
    else if (cl)  reg_q <= 4'd0;
    else if (ld)  reg_q <= ld_data;
    else if (inc) reg_q <= reg_q + 4'd1;
    else if (dec) reg_q <= reg_q - 4'd1;
    else if (sr)  reg_q <= {ir, reg_q[3:1]};
    else if (sl)  reg_q <= {reg_q[2:0], il};
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Issues one command and records outputs each cycle until ready returns.
  task automatic run_trace(input logic [2:0] op, input logic [3:0] arg,
                           input logic fill, input int abort_at);
    bit ok;
    tr_len = 0;
    wait_ready(ok);
    if (!ok) return;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_fill  = fill;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_arg   = 4'($urandom);
    cmd_fill  = 1'($urandom);
    for (int i = 1; i < 48; i++) begin
      abort = (i == abort_at);
      @(negedge clk);
      tr_strb[i] = {cl, ld, inc, dec, sr, sl};
      tr_ir[i]   = ir;
      tr_il[i]   = il;
      tr_ldd[i]  = ld_data;
      tr_done[i] = done;
      if (cmd_ready) begin
        tr_len = i;
        break;
      end
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_INC;
    cmd_arg   = 4'd5;
    cmd_fill  = 1'b0;
    abort     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_compared++;
    if ({cmd_ready, busy, done, cl, ld, inc, dec, sr, sl, ir, il, ld_data} !== {3'b100, 8'b0, 4'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs: got rdy=%b busy=%b done=%b strb=%b ir=%b il=%b ldd=%h, want rdy=1 rest 0",
               cmd_ready, busy, done, {cl, ld, inc, dec, sr, sl}, ir, il, ld_data);
    end
    n_compared++;
    if (reg_q !== 4'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_reg: got %b want 0000", reg_q);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    n_compared++;
    if ({cmd_ready, done, cl, ld, inc, dec, sr, sl} !== 8'b10000000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_release_idle: got rdy=%b done=%b strb=%b, want rdy=1 done=0 strb=0",
               cmd_ready, done, {cl, ld, inc, dec, sr, sl});
    end
  endtask

  task automatic test_commands();
    logic [2:0]  op;
    logic [3:0]  arg;
    logic        fill;
    int          abort_at, n, n_eff, exp_len;
    logic [3:0]  v;
    logic [5:0]  e_strb;
    logic        e_ir, e_il, e_done;
    logic [3:0]  e_ldd;
    logic [12:0] got, want;
    model_q = 4'd0;
    for (int idx = 0; idx < 52; idx++) begin
      abort_at = 0;
      fill     = 1'b0;
      arg      = 4'd0;
      op       = OP_NOP;
      case (idx)
        0:  begin op = OP_LOAD; arg = 4'b1010; end
        1:  begin op = OP_LOAD; arg = 4'b1110; end
        2:  begin op = OP_INC;  arg = 4'd3; end
        3:  begin op = OP_DEC;  arg = 4'd0; abort_at = 1; end
        4:  begin op = OP_CLR;  arg = 4'd9; end
        5:  begin op = OP_SHR;  arg = 4'd2; fill = 1'b1; end
        6:  begin op = OP_SHL;  arg = 4'd1; fill = 1'b0; end
        7:  begin op = OP_LOAD; arg = 4'b1011; end
        8:  begin op = OP_ROR;  arg = 4'd3; end
        9:  begin op = OP_ROR;  arg = 4'd4; end
        10: begin op = OP_SHL;  arg = 4'd10; fill = 1'b1; abort_at = 3; end
        11: begin op = OP_NOP;  arg = 4'd7; abort_at = 1; end
        12: begin op = OP_INC;  arg = 4'd15; end
        default: begin
          op   = 3'($urandom_range(0, 7));
          arg  = 4'($urandom_range(0, 15));
          fill = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) == 0) abort_at = $urandom_range(1, 16);
        end
      endcase
      if (op == OP_NOP) n = 0;
      else if (op == OP_CLR || op == OP_LOAD) n = 1;
      else n = int'(arg);
      n_eff   = (abort_at >= 1 && abort_at <= n) ? abort_at : n;
      exp_len = ((n_eff > 0) ? n_eff : 1) + 1;
      run_trace(op, arg, fill, abort_at);
      n_compared++;
      if (tr_len != exp_len) begin
        n_mismatched++;
        $display("[TB] FAIL cmd%0d_latency: op=%0d arg=%0d ready after %0d cycles, want %0d",
                 idx, op, arg, tr_len, exp_len);
        // Resynchronise so one broken command does not cascade.
        model_q = reg_q;
        continue;
      end
      v = model_q;
      for (int i = 1; i < exp_len; i++) begin
        e_strb = 6'b0;
        e_ir   = 1'b0;
        e_il   = 1'b0;
        e_ldd  = 4'd0;
        e_done = (i == exp_len - 1);
        if (i <= n_eff) begin
          case (op)
            OP_CLR:  begin e_strb = 6'b100000; v = 4'd0; end
            OP_LOAD: begin e_strb = 6'b010000; e_ldd = arg; v = arg; end
            OP_INC:  begin e_strb = 6'b001000; v = v + 4'd1; end
            OP_DEC:  begin e_strb = 6'b000100; v = v - 4'd1; end
            OP_SHR:  begin e_strb = 6'b000010; e_ir = fill; v = {fill, v[3:1]}; end
            OP_SHL:  begin e_strb = 6'b000001; e_il = fill; v = {v[2:0], fill}; end
            OP_ROR:  begin e_strb = 6'b000010; e_ir = v[0]; v = {v[0], v[3:1]}; end
            default: ;
          endcase
        end
        want = {e_strb, e_ir, e_il, e_ldd, e_done};
        got  = {tr_strb[i], tr_ir[i], tr_il[i], tr_ldd[i], tr_done[i]};
        n_compared++;
        if (got !== want) begin
          n_mismatched++;
          $display("[TB] FAIL cmd%0d_cycle%0d: op=%0d got strb=%b ir=%b il=%b ldd=%b done=%b, want strb=%b ir=%b il=%b ldd=%b done=%b",
                   idx, i, op, got[12:7], got[6], got[5], got[4:1], got[0],
                   want[12:7], want[6], want[5], want[4:1], want[0]);
        end
      end
      model_q = v;
      n_compared++;
      if (reg_q !== model_q) begin
        n_mismatched++;
        $display("[TB] FAIL cmd%0d_reg: op=%0d arg=%0d got %b want %b", idx, op, arg, reg_q, model_q);
        model_q = reg_q;
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    wait_ready(ok);
    n_compared++;
    if (!ok) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_ready_timeout: got ready=0 want 1");
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = OP_INC;
    cmd_arg   = 4'd5;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_compared++;
    if (inc !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_third_strobe: got inc=%b want 1", inc);
    end
    rst_n = 1'b0;
    #1;
    n_compared++;
    if ({cmd_ready, busy, done, cl, ld, inc, dec, sr, sl, ir, il, ld_data, reg_q} !== {3'b100, 8'b0, 4'b0, 4'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_outputs: got rdy=%b busy=%b done=%b strb=%b ir=%b il=%b ldd=%h q=%b, want rdy=1 rest 0",
               cmd_ready, busy, done, {cl, ld, inc, dec, sr, sl}, ir, il, ld_data, reg_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_compared++;
    if ({cmd_ready, done, cl, ld, inc, dec, sr, sl, reg_q} !== {2'b10, 6'b0, 4'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_train_stopped: got rdy=%b done=%b strb=%b q=%b, want rdy=1 done=0 strb=0 q=0",
               cmd_ready, done, {cl, ld, inc, dec, sr, sl}, reg_q);
    end
  endtask

  task automatic test_back_to_back();
    bit         ok;
    logic [7:0] want [1:5];
    logic [7:0] got;
    want[1] = {1'b0, 6'b001000, 1'b0};
    want[2] = {1'b0, 6'b001000, 1'b1};
    want[3] = {1'b1, 6'b000000, 1'b0};
    want[4] = {1'b0, 6'b100000, 1'b1};
    want[5] = {1'b1, 6'b000000, 1'b0};
    wait_ready(ok);
    n_compared++;
    if (!ok) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_ready_timeout: got ready=0 want 1");
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = OP_INC;
    cmd_arg   = 4'd2;
    @(posedge clk);
    #1;
    // CLR queued and held valid while the INC train runs.
    cmd_op  = OP_CLR;
    cmd_arg = 4'd6;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      got = {cmd_ready, cl, ld, inc, dec, sr, sl, done};
      n_compared++;
      if (got !== want[c]) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_cycle%0d: got rdy=%b strb=%b done=%b, want rdy=%b strb=%b done=%b",
                 c, got[7], got[6:1], got[0], want[c][7], want[c][6:1], want[c][0]);
      end
      @(posedge clk);
      #1;
      if (c == 3) cmd_valid = 1'b0;
    end
    n_compared++;
    if (reg_q !== 4'd0) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_reg: got %b want 0000", reg_q);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_commands();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
